// File: rtl/tag_collision_tracker.sv
// Outstanding-tag table: retires, then per-lane issues with collision/overflow detection.
// Optional embedded properties are compiled in with TAG_COLLISION_TRACKER_FORMAL_EN.
module tag_collision_tracker #(
  parameter int LANES = 8,
  parameter int TAG_W = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [LANES-1:0]       iss_vld,
  input  logic [LANES*TAG_W-1:0] iss_tag,
  input  logic                   ret_vld,
  input  logic [TAG_W-1:0]       ret_tag,
  input  logic                   err_clr,
  output logic [LANES-1:0]       iss_acc,
  output logic [LANES-1:0]       iss_col,
  output logic [LANES-1:0]       iss_ovf,
  output logic                   ret_miss,
  output logic                   err,
  output logic [OCC_W-1:0]       occupancy,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       col_cnt
);

  localparam int SUM_W = CNT_W + 5;

  logic [DEPTH-1:0] vld_r;
  logic [TAG_W-1:0] tag_r [DEPTH];
  logic [LANES-1:0] acc_r, col_r, ovf_r;
  logic             miss_r, err_r, full_r, empty_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] cnt_r;

  logic [DEPTH-1:0] vld_s;
  logic [TAG_W-1:0] tag_s [DEPTH];
  logic [LANES-1:0] acc_s, col_s, ovf_s;
  logic             hit_s, miss_s, match_s, slot_s, take_s, err_any_s, err_nxt_s;
  logic [TAG_W-1:0] lane_tag_s;
  logic [OCC_W-1:0] acc_n_s, occ_nxt_s;
  logic [4:0]       col_n_s;
  logic [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next table and flags: retire first, then lanes in ascending order see earlier allocations
  always_comb begin
    vld_s   = vld_r;
    tag_s   = tag_r;
    hit_s   = 1'b0;
    acc_s   = {LANES{1'b0}};
    col_s   = {LANES{1'b0}};
    ovf_s   = {LANES{1'b0}};
    acc_n_s = {OCC_W{1'b0}};
    col_n_s = 5'd0;
    match_s = 1'b0;
    slot_s  = 1'b0;
    take_s  = 1'b0;
    lane_tag_s = {TAG_W{1'b0}};
    for (int e = 0; e < DEPTH; e++) begin
      take_s   = ret_vld && vld_s[e] && (tag_s[e] == ret_tag);
      vld_s[e] = vld_s[e] & ~take_s;
      hit_s    = hit_s | take_s;
    end
    miss_s = ret_vld & ~hit_s;
    for (int i = 0; i < LANES; i++) begin
      lane_tag_s = iss_tag[i*TAG_W +: TAG_W];
      match_s    = 1'b0;
      slot_s     = 1'b0;
      // Accepted lower lanes are already valid entries, so this also catches same-cycle duplicates
      for (int e = 0; e < DEPTH; e++) begin
        match_s = match_s | (vld_s[e] && (tag_s[e] == lane_tag_s));
      end
      if (iss_vld[i] && match_s) begin
        col_s[i] = 1'b1;
      end else if (iss_vld[i]) begin
        for (int e = 0; e < DEPTH; e++) begin
          take_s   = !slot_s && !vld_s[e];
          vld_s[e] = vld_s[e] | take_s;
          tag_s[e] = take_s ? lane_tag_s : tag_s[e];
          slot_s   = slot_s | take_s;
        end
        acc_s[i] = slot_s;
        ovf_s[i] = ~slot_s;
      end else begin
        col_s[i] = 1'b0;
      end
      acc_n_s = acc_n_s + OCC_W'(acc_s[i]);
      col_n_s = col_n_s + 5'(col_s[i]);
    end
    occ_nxt_s = occ_r - OCC_W'(hit_s) + acc_n_s;
    sum_s     = SUM_W'(cnt_r) + SUM_W'(col_n_s);
    if (sum_s > SUM_W'({CNT_W{1'b1}})) begin
      cnt_nxt_s = {CNT_W{1'b1}};
    end else begin
      cnt_nxt_s = sum_s[CNT_W-1:0];
    end
    err_any_s = (|col_s) | (|ovf_s) | miss_s;
    err_nxt_s = err_any_s | (err_r & ~err_clr);
  end

  // Table and registered status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_r   <= {DEPTH{1'b0}};
      for (int e = 0; e < DEPTH; e++) begin
        tag_r[e] <= {TAG_W{1'b0}};
      end
      acc_r   <= {LANES{1'b0}};
      col_r   <= {LANES{1'b0}};
      ovf_r   <= {LANES{1'b0}};
      miss_r  <= 1'b0;
      err_r   <= 1'b0;
      occ_r   <= {OCC_W{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      vld_r   <= vld_s;
      tag_r   <= tag_s;
      acc_r   <= acc_s;
      col_r   <= col_s;
      ovf_r   <= ovf_s;
      miss_r  <= miss_s;
      err_r   <= err_nxt_s;
      occ_r   <= occ_nxt_s;
      full_r  <= (occ_nxt_s == OCC_W'(DEPTH));
      empty_r <= (occ_nxt_s == {OCC_W{1'b0}});
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign iss_acc   = acc_r;
  assign iss_col   = col_r;
  assign iss_ovf   = ovf_r;
  assign ret_miss  = miss_r;
  assign err       = err_r;
  assign occupancy = occ_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign col_cnt   = cnt_r;

`ifdef TAG_COLLISION_TRACKER_FORMAL_EN
  generate
    for (genvar a = 0; a < DEPTH; a++) begin : g_uniq_a
      for (genvar b = a + 1; b < DEPTH; b++) begin : g_uniq_b
        a_unique_tag: assert property (@(posedge clk) disable iff (!rstn)
          !(vld_r[a] && vld_r[b] && (tag_r[a] == tag_r[b])));
      end
    end
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      a_flags_excl: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0({acc_r[l], col_r[l], ovf_r[l]}));
      m_no_ret_same_tag: assume property (@(posedge clk) disable iff (!rstn)
        !(ret_vld && iss_vld[l] && (iss_tag[l*TAG_W +: TAG_W] == ret_tag)));
    end
  endgenerate

  a_occ_count: assert property (@(posedge clk) disable iff (!rstn)
    occ_r == OCC_W'($countones(vld_r)));
  a_full_no_acc: assert property (@(posedge clk) disable iff (!rstn)
    (full_r && !hit_s) |-> (acc_s == {LANES{1'b0}}));
`endif

endmodule

// File: tb/tb_tag_collision_tracker.sv
// Directed scenarios plus randomized traffic checked against a queue-based table model.
module tb_tag_collision_tracker;
  localparam int LANES = 8;
  localparam int TAG_W = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [LANES-1:0]       iss_vld;
  logic [LANES*TAG_W-1:0] iss_tag;
  logic                   ret_vld;
  logic [TAG_W-1:0]       ret_tag;
  logic                   err_clr;
  logic [LANES-1:0]       iss_acc, iss_col, iss_ovf;
  logic                   ret_miss, err, full, empty;
  logic [OCC_W-1:0]       occupancy;
  logic [CNT_W-1:0]       col_cnt;

  always #5 clk = ~clk;

  tag_collision_tracker #(.LANES(LANES), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .iss_vld(iss_vld), .iss_tag(iss_tag), .ret_vld(ret_vld),
    .ret_tag(ret_tag), .err_clr(err_clr), .iss_acc(iss_acc), .iss_col(iss_col),
    .iss_ovf(iss_ovf), .ret_miss(ret_miss), .err(err), .occupancy(occupancy),
    .full(full), .empty(empty), .col_cnt(col_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference: set of outstanding tags as a queue; entry positions are irrelevant to outputs
  logic [TAG_W-1:0] mq[$];
  logic             m_err;
  int               m_cnt;
  logic [LANES-1:0] e_acc, e_col, e_ovf;
  logic             e_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    iss_vld = '0;
    iss_tag = '0;
    ret_vld = 1'b0;
    ret_tag = '0;
    err_clr = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [TAG_W-1:0] t);
    iss_vld[i] = 1'b1;
    iss_tag[i*TAG_W +: TAG_W] = t;
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_cnt = 0;
    e_acc = '0; e_col = '0; e_ovf = '0; e_miss = 1'b0;
  endtask

  function automatic bit in_set(input logic [TAG_W-1:0] t);
    foreach (mq[k]) if (mq[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int idx;
    logic [TAG_W-1:0] t;
    e_acc = '0; e_col = '0; e_ovf = '0; e_miss = 1'b0;
    if (ret_vld) begin
      idx = -1;
      for (int k = 0; k < mq.size(); k++) if (mq[k] == ret_tag) idx = k;
      if (idx >= 0) mq.delete(idx);
      else e_miss = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      if (iss_vld[i]) begin
        t = iss_tag[i*TAG_W +: TAG_W];
        if (in_set(t)) e_col[i] = 1'b1;
        else if (mq.size() == DEPTH) e_ovf[i] = 1'b1;
        else begin
          mq.push_back(t);
          e_acc[i] = 1'b1;
        end
      end
    end
    m_cnt = m_cnt + $countones(e_col);
    if (m_cnt > 255) m_cnt = 255;
    if (e_col != 0 || e_ovf != 0 || e_miss) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic check_all(input string p);
    check({p, "_acc"}, 32'(iss_acc), 32'(e_acc));
    check({p, "_col"}, 32'(iss_col), 32'(e_col));
    check({p, "_ovf"}, 32'(iss_ovf), 32'(e_ovf));
    check({p, "_miss"}, 32'(ret_miss), 32'(e_miss));
    check({p, "_occ"}, 32'(occupancy), 32'(mq.size()));
    check({p, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
    check({p, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({p, "_cnt"}, 32'(col_cnt), 32'(m_cnt));
    check({p, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic step(input string p);
    model_step();
    @(posedge clk);
    #1;
    check_all(p);
    clear_in();
  endtask

  task automatic do_reset();
    clear_in();
    rstn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("rst");
    rstn = 1'b1;
  endtask

  initial begin
    clear_in();
    model_reset();
    #2;
    do_reset();

    // Single accept
    set_lane(0, 16'h0005); step("t1");
    check("t1_acc_k", 32'(iss_acc), 32'h01);
    check("t1_occ_k", 32'(occupancy), 32'd1);

    // Same-cycle duplicate: lower lane wins, then err_clr
    set_lane(2, 16'h00AA); set_lane(5, 16'h00AA); step("t2");
    check("t2_acc_k", 32'(iss_acc), 32'h04);
    check("t2_col_k", 32'(iss_col), 32'h20);
    check("t2_cnt_k", 32'(col_cnt), 32'd1);
    err_clr = 1'b1; step("t2c");
    check("t2c_err_k", 32'(err), 32'd0);

    // Fill, overflow, then retire+issue on a full table
    do_reset();
    for (int i = 0; i < LANES; i++) set_lane(i, 16'(i));
    step("f1");
    for (int i = 0; i < LANES; i++) set_lane(i, 16'(i + 8));
    step("f2");
    check("f2_full_k", 32'(full), 32'd1);
    set_lane(0, 16'h0100); step("f3");
    check("f3_ovf_k", 32'(iss_ovf), 32'h01);
    check("f3_full_k", 32'(full), 32'd1);
    ret_vld = 1'b1; ret_tag = 16'h0003; set_lane(0, 16'h0200); set_lane(1, 16'h0201); step("f4");
    check("f4_acc_k", 32'(iss_acc), 32'h01);
    check("f4_occ_k", 32'(occupancy), 32'd16);
    // Retire and reissue the same tag in one cycle
    ret_vld = 1'b1; ret_tag = 16'h0007; set_lane(1, 16'h0007); step("r7");
    check("r7_acc_k", 32'(iss_acc), 32'h02);
    check("r7_col_k", 32'(iss_col), 32'h00);
    check("r7_occ_k", 32'(occupancy), 32'd16);

    // Retire on an empty table
    do_reset();
    ret_vld = 1'b1; ret_tag = 16'h1234; step("em");
    check("em_miss_k", 32'(ret_miss), 32'd1);
    check("em_err_k", 32'(err), 32'd1);

    // Asynchronous reset mid-stream with occupancy 9
    do_reset();
    for (int i = 0; i < LANES; i++) set_lane(i, 16'(16'h0040 + i));
    step("a1");
    set_lane(0, 16'h0050); step("a2");
    check("a2_occ_k", 32'(occupancy), 32'd9);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all("async");
    check("async_empty_k", 32'(empty), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    set_lane(0, 16'h0005); step("a3");
    check("a3_acc_k", 32'(iss_acc), 32'h01);

    // Randomized traffic over a small tag space to force collisions, overflow and misses
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < LANES; i++)
        if ($urandom_range(99) < 35) set_lane(i, 16'($urandom_range(47)));
      if ($urandom_range(99) < 70) begin
        ret_vld = 1'b1;
        if (mq.size() > 0 && $urandom_range(99) < 80)
          ret_tag = mq[$urandom_range(mq.size() - 1)];
        else
          ret_tag = 16'($urandom_range(63));
      end
      err_clr = ($urandom_range(99) < 20);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
